decode_stage: RTL and testbench

//  RV32I decode stage with a valid/ready handshake; replaces the hlt-stalled decoder.

---
 rtl/decode_stage.sv | 152 +++++++++++++++
 tb/tb_decode_stage.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with valid/ready handshake and optional 2-entry skid buffer
module decode_stage #(
  parameter int PC_W        = 32,
  parameter int SKID        = 1,
  parameter int CHECK_FUNCT = 1,
  parameter int EN_M        = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [31:0]     out_imm,
  output logic [10:0]     out_cls,
  output logic            out_mul,
  output logic            out_rd_we,
  output logic            out_rs1_en,
  output logic            out_rs2_en,
  output logic            out_illegal
);
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     inst;
    logic [31:0]     imm;
    logic [10:0]     cls;
    logic            mul;
    logic            rd_we;
    logic            rs1_en;
    logic            rs2_en;
    logic            illegal;
  } ent_t;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state, state_n;
  ent_t d, main_q, skid_q;
  logic load_main, load_skid, skid_to_main, rdy_q, alive_q, acc, pop;
  logic [10:0] c;
  logic [2:0] f3;
  logic [6:0] f7;
  logic known, bad_f, ill, itype;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign f3 = in_inst[14:12];
  assign f7 = in_inst[31:25];
  // class bits {system,jal,jalr,branch,lui,alur,store,auipc,alui,fence,load}
  assign c = {in_inst[6:2] == 5'b11100, in_inst[6:2] == 5'b11011, in_inst[6:2] == 5'b11001,
              in_inst[6:2] == 5'b11000, in_inst[6:2] == 5'b01101, in_inst[6:2] == 5'b01100,
              in_inst[6:2] == 5'b01000, in_inst[6:2] == 5'b00101, in_inst[6:2] == 5'b00100,
              in_inst[6:2] == 5'b00011, in_inst[6:2] == 5'b00000};
  assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u = {in_inst[31:12], 12'b0};
  assign imm_j = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
  // combinational decode of the presented instruction, captured only on accept
  always_comb begin
    known = (in_inst[1:0] == 2'b11) & (|c);
    itype = c[0] | c[1] | c[2] | c[8] | c[10];
    bad_f = (c[0] & (f3 == 3'd3 | f3 == 3'd6 | f3 == 3'd7))
          | (c[4] & (f3 > 3'd2))
          | (c[7] & (f3 == 3'd2 | f3 == 3'd3))
          | (c[8] & (f3 != 3'd0))
          | (c[2] & f3 == 3'd1 & f7 != 7'h00)
          | (c[2] & f3 == 3'd5 & f7 != 7'h00 & f7 != 7'h20)
          | (c[5] & !(f7 == 7'h00 | f7 == 7'h20 | ((EN_M != 0) & f7 == 7'h01)))
          | (c[5] & f7 == 7'h20 & !(f3 == 3'd0 | f3 == 3'd5));
    ill = !known | ((CHECK_FUNCT != 0) & bad_f);
    d.pc      = in_pc;
    d.inst    = in_inst;
    d.illegal = ill;
    d.cls     = ill ? 11'b0 : c;
    d.imm     = ill ? 32'b0 : itype ? imm_i : c[4] ? imm_s : c[7] ? imm_b :
                (c[6] | c[3]) ? imm_u : c[9] ? imm_j : 32'b0;
    d.rd_we   = !ill & (c[0] | c[2] | c[5] | c[6] | c[3] | c[9] | c[8] | c[10]) & (in_inst[11:7] != 5'd0);
    d.rs1_en  = !ill & (c[0] | c[4] | c[2] | c[5] | c[7] | c[8]);
    d.rs2_en  = !ill & (c[4] | c[5] | c[7]);
    d.mul     = !ill & c[5] & (EN_M != 0) & (f7 == 7'h01);
  end
  assign out_valid = state != EMPTY;
  assign in_ready  = (SKID != 0) ? rdy_q : alive_q & (state == EMPTY | out_ready);
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  // occupancy FSM; flush overrides everything and drops a same-cycle accept
  always_comb begin
    state_n      = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state)
      EMPTY: if (acc) begin state_n = ONE; load_main = 1'b1; end
      ONE: begin
        if (acc & !pop) begin state_n = TWO; load_skid = 1'b1; end
        else if (pop & !acc) state_n = EMPTY;
        else if (acc & pop) load_main = 1'b1;
      end
      TWO: if (pop) begin state_n = ONE; skid_to_main = 1'b1; end
      default: state_n = EMPTY;
    endcase
    if (flush) begin
      state_n   = EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
      skid_to_main = 1'b0;
    end
  end
  // state register and registered in_ready (low in reset, high from the first edge after)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= EMPTY;
      rdy_q   <= 1'b0;
      alive_q <= 1'b0;
    end else begin
      state   <= state_n;
      rdy_q   <= state_n != TWO;
      alive_q <= 1'b1;
    end
  end
  // entry storage: main feeds the outputs, skid holds the overflow entry
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) main_q <= d;
      else if (skid_to_main) main_q <= skid_q;
      if (load_skid) skid_q <= d;
    end
  end
  assign out_pc      = main_q.pc;
  assign out_opcode  = main_q.inst[6:0];
  assign out_rd      = main_q.inst[11:7];
  assign out_rs1     = main_q.inst[19:15];
  assign out_rs2     = main_q.inst[24:20];
  assign out_funct3  = main_q.inst[14:12];
  assign out_funct7  = main_q.inst[31:25];
  assign out_imm     = main_q.imm;
  assign out_cls     = main_q.cls;
  assign out_mul     = main_q.mul;
  assign out_rd_we   = main_q.rd_we;
  assign out_rs1_en  = main_q.rs1_en;
  assign out_rs2_en  = main_q.rs2_en;
  assign out_illegal = main_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of decode_stage handshake, decode fields, flush and reset
module tb_decode_stage;
  logic clk = 1'b0, rstn = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_inst = 32'b0, in_pc = 32'b0;
  logic in_ready, out_valid, out_mul, out_rd_we, out_rs1_en, out_rs2_en, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [6:0] out_opcode, out_funct7;
  logic [4:0] out_rd, out_rs1, out_rs2;
  logic [2:0] out_funct3;
  logic [10:0] out_cls;
  logic n_in_ready, n_out_valid, n_out_mul, n_out_rd_we, n_out_rs1_en, n_out_rs2_en, n_out_illegal;
  logic [31:0] n_out_pc, n_out_imm;
  logic [6:0] n_out_opcode, n_out_funct7;
  logic [4:0] n_out_rd, n_out_rs1, n_out_rs2;
  logic [2:0] n_out_funct3;
  logic [10:0] n_out_cls;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  decode_stage dut (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
    .out_cls(out_cls), .out_mul(out_mul), .out_rd_we(out_rd_we), .out_rs1_en(out_rs1_en),
    .out_rs2_en(out_rs2_en), .out_illegal(out_illegal)
  );
  decode_stage #(.EN_M(0)) dut_nm (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(n_out_valid), .out_ready(out_ready),
    .out_pc(n_out_pc), .out_opcode(n_out_opcode), .out_rd(n_out_rd), .out_rs1(n_out_rs1),
    .out_rs2(n_out_rs2), .out_funct3(n_out_funct3), .out_funct7(n_out_funct7), .out_imm(n_out_imm),
    .out_cls(n_out_cls), .out_mul(n_out_mul), .out_rd_we(n_out_rd_we), .out_rs1_en(n_out_rs1_en),
    .out_rs2_en(n_out_rs2_en), .out_illegal(n_out_illegal)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_imm", out_imm, 0);
    rstn = 1'b1;
    step();
    chk("ready_after_rst", in_ready, 1);
    in_valid = 1'b1; out_ready = 1'b1; in_inst = 32'hFFF00093; in_pc = 32'h100;
    step();
    chk("addi_valid", out_valid, 1);
    chk("addi_cls", out_cls, 11'h004);
    chk("addi_imm", out_imm, 32'hFFFFFFFF);
    chk("addi_rd_we", out_rd_we, 1);
    chk("addi_rd", out_rd, 1);
    chk("addi_pc", out_pc, 32'h100);
    in_inst = 32'hFE000EE3; in_pc = 32'h104;
    step();
    chk("beq_imm", out_imm, 32'hFFFFFFFC);
    chk("beq_cls", out_cls, 11'h080);
    chk("beq_rs_en", {out_rs1_en, out_rs2_en}, 2'b11);
    chk("beq_rd_we", out_rd_we, 0);
    chk("beq_pc", out_pc, 32'h104);
    in_inst = 32'h123450B7; in_pc = 32'h108;
    step();
    chk("lui_imm", out_imm, 32'h12345000);
    chk("lui_cls", out_cls, 11'h040);
    chk("lui_rs1_en", out_rs1_en, 0);
    in_inst = 32'h00002003; in_pc = 32'h10C;
    step();
    chk("lw_x0_rd_we", out_rd_we, 0);
    chk("lw_x0_cls", out_cls, 11'h001);
    chk("lw_x0_rs1_en", out_rs1_en, 1);
    in_inst = 32'h00003003; in_pc = 32'h110;
    step();
    chk("load_f3_ill", out_illegal, 1);
    chk("load_f3_cls", out_cls, 0);
    in_valid = 1'b0;
    step();
    chk("drained", out_valid, 0);
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 32'h200;
    step();
    chk("skid_ready1", in_ready, 1);
    in_inst = 32'h00200113; in_pc = 32'h204;
    step();
    chk("skid_full_ready", in_ready, 0);
    chk("skid_head_pc", out_pc, 32'h200);
    in_inst = 32'h00300193; in_pc = 32'h208;
    step();
    chk("skid_hold_ready", in_ready, 0);
    chk("skid_hold_pc", out_pc, 32'h200);
    out_ready = 1'b1;
    step();
    chk("skid_second_pc", out_pc, 32'h204);
    chk("skid_second_imm", out_imm, 2);
    chk("skid_ready_again", in_ready, 1);
    step();
    chk("skid_third_pc", out_pc, 32'h208);
    chk("skid_third_imm", out_imm, 3);
    in_valid = 1'b0;
    step();
    chk("skid_empty", out_valid, 0);
    in_valid = 1'b1; in_inst = 32'h02000033; in_pc = 32'h300;
    step();
    chk("mul_flag", out_mul, 1);
    chk("mul_legal", out_illegal, 0);
    chk("mul_cls", out_cls, 11'h020);
    chk("nom_illegal", n_out_illegal, 1);
    chk("nom_cls", n_out_cls, 0);
    chk("nom_mul", n_out_mul, 0);
    in_valid = 1'b0;
    step();
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 32'h400;
    step();
    in_pc = 32'h404;
    step();
    chk("pre_flush_full", in_ready, 0);
    flush = 1'b1; in_pc = 32'h408;
    step();
    chk("flush_valid", out_valid, 0);
    flush = 1'b0; in_valid = 1'b0;
    step();
    chk("flush_dropped", out_valid, 0);
    in_valid = 1'b1; in_inst = 32'h00500293; in_pc = 32'h500;
    step();
    chk("pre_rst_valid", out_valid, 1);
    #2 rstn = 1'b0;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_pc", out_pc, 0);
    chk("async_imm", out_imm, 0);
    chk("async_ready", in_ready, 0);
    #3 rstn = 1'b1;
    in_valid = 1'b0;
    step();
    in_valid = 1'b1; out_ready = 1'b1; in_inst = 32'h00000000; in_pc = 32'h600;
    step();
    chk("zero_valid", out_valid, 1);
    chk("zero_illegal", out_illegal, 1);
    chk("zero_cls", out_cls, 0);
    chk("zero_rs1_en", out_rs1_en, 0);
    in_valid = 1'b0;
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
